// File: rtl/ssd_display_driver.sv
// Binary-to-BCD (sequential double-dabble) plus 4-digit multiplexed common-anode 7-seg driver.
// Optional macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits (ones digit always shown).
module ssd_display_driver #(
  parameter int unsigned DATA_W       = 13,
  parameter int unsigned REFRESH_BITS = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] value,
  output logic [3:0]        anode,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ITER_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DATA_W-1:0]       bin_q;
  logic [15:0]             bcd_q;
  logic [15:0]             bcd_adj;
  logic [ITER_W-1:0]       iter_q;
  logic [15:0]             digits_q;
  logic [REFRESH_BITS-1:0] cnt_q;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic [3:0]              blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = SHIFT;
      SHIFT:   if (iter_q == ITER_W'(DATA_W - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      digits_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bin_q  <= value;
          bcd_q  <= '0;
          iter_q <= '0;
          busy   <= 1'b1;
          done   <= 1'b0;
        end
        SHIFT: begin
          // The top BCD bit falls off the shift; it is always 0 for values up to 8191.
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          iter_q         <= iter_q + ITER_W'(1);
          done           <= 1'b0;
        end
        COMMIT: begin
          digits_q <= bcd_q;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_q + REFRESH_BITS'(1);
  end

  assign sel   = cnt_q[REFRESH_BITS-1 -: 2];
  assign digit = digits_q[4*sel +: 4];

  always_comb begin
    blank = '0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    blank[3] = (digits_q[15:12] == 4'd0);
    blank[2] = blank[3] && (digits_q[11:8] == 4'd0);
    blank[1] = blank[2] && (digits_q[7:4] == 4'd0);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode <= '1;
      seg   <= '1;
    end else begin
      anode <= ~(4'b0001 << sel);
      seg   <= blank[sel] ? 7'h7F : decode(digit);
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Randomized self-checking bench for ssd_display_driver against a decimal-arithmetic reference model.
module tb_ssd_display_driver;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] value = '0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  ssd_display_driver #(
    .DATA_W      (13),
    .REFRESH_BITS(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .value(value),
    .anode(anode),
    .seg  (seg),
    .dp   (dp),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] an_tbl  [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int         pow10   [4]  = '{1, 10, 100, 1000};

  // Reference model: edges since reset release, captured value, displayed decimal digits.
  int k;
  int cap;
  int digs [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int sel);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    bit lead = 1'b1;
    for (int i = 3; i >= sel; i--) if (digs[i] != 0) lead = 1'b0;
    if (sel != 0 && lead) return 7'h7F;
`endif
    return seg_tbl[digs[sel]];
  endfunction

  task automatic step();
    int         pos;
    int         sel;
    logic [3:0] ea;
    logic [6:0] es;
    logic       eb;
    logic       ed;
    @(posedge clk);
    if (reset) begin
      k++;
      pos = (k - 1) % 15;
      sel = ((k - 1) % 16) / 4;
      if (pos == 0) cap = int'(value);
      ea = an_tbl[sel];
      es = model_seg(sel);
      eb = (pos != 14);
      ed = (pos == 14);
      if (pos == 14) for (int i = 0; i < 4; i++) digs[i] = (cap / pow10[i]) % 10;
    end else begin
      ea = 4'hF;
      es = 7'h7F;
      eb = 1'b0;
      ed = 1'b0;
    end
    #1;
    check("anode", 32'(anode), 32'(ea));
    check("seg",   32'(seg),   32'(es));
    check("busy",  32'(busy),  32'(eb));
    check("done",  32'(done),  32'(ed));
    check("dp",    32'(dp),    32'd1);
    if (reset) check("one_low", 32'($countones(~anode)), 32'd1);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    k     = 0;
    for (int i = 0; i < 4; i++) digs[i] = 0;
    #1;
    check("rst_anode", 32'(anode), 32'hF);
    check("rst_seg",   32'(seg),   32'h7F);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    run(n);
    reset = 1'b1;
  endtask

  task automatic align_capture();
    for (int i = 0; i < 16 && (k % 15) != 1; i++) step();
  endtask

  initial begin
    k   = 0;
    cap = 0;
    for (int i = 0; i < 4; i++) digs[i] = 0;

    apply_reset(3);
    value = 13'd1234;
    run(48);

    // abort mid-conversion, then a fresh conversion of the maximum value
    apply_reset(3);
    value = 13'd8191;
    run(50);

    value = 13'd1234;
    align_capture();
    run(5);
    value = 13'd42;
    run(40);

    value = 13'd7;
    run(40);
    value = 13'd0;
    run(40);
    value = 13'd1000;
    run(40);

    repeat (250) begin
      case ($urandom_range(0, 7))
        0:       value = 13'd8191;
        1:       value = 13'd0;
        2, 3:    value = 13'($urandom_range(0, 8191));
        default: ;
      endcase
      step();
    end

    run($urandom_range(3, 12));
    apply_reset(3);
    value = 13'($urandom_range(0, 8191));
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
